sram_access_arbiter: RTL and testbench

Shares the single-port 128x8 SRAM between two requesters: the I2C target protocol engine (requester 0) and the host/debug port (requester 1). It arbitrates per beat and lets one requester lock the SRAM for sequential bursts, such as I2C auto-increment reads. It drives the SRAM command pins from a register stage and returns read data to whichever requester issued the access.

---
 rtl/sram_arb_pkg.sv | 16 +
 rtl/sram_access_arbiter_if.sv | 26 ++
 rtl/sram_access_arbiter_arb_rr2.sv | 18 +
 rtl/sram_access_arbiter.sv | 115 +++++++++++
 tb/tb_sram_access_arbiter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester SRAM access arbiter.
package sram_arb_pkg;

   localparam int SRAM_ADDR_W = 7;
   localparam int SRAM_DATA_W = 8;

   localparam logic REQ_I2C  = 1'b0;
   localparam logic REQ_HOST = 1'b1;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCK0    = 2'd1,
      LOCK1    = 2'd2
   } lock_state_e;

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Requester-side beat/response bus of the SRAM arbiter; bit i / slice i belongs to requester i.
interface sram_req_if
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W = SRAM_ADDR_W,
   parameter int DATA_W = SRAM_DATA_W
);
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [1:0]          req_write;
   logic [1:0]          req_lock;
   logic [2*ADDR_W-1:0] req_addr;
   logic [2*DATA_W-1:0] req_wdata;
   logic [1:0]          rsp_valid;
   logic [DATA_W-1:0]   rsp_rdata;

   modport master (
      output req_valid, req_write, req_lock, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_lock, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/sram_access_arbiter_arb_rr2.sv
// Two-input grant generator: round-robin by pointer, or fixed priority (requester 0 first)
// when SRAM_ARB_FIXED_PRIO_EN is defined, in which case the pointer input does not exist.
module arb_rr2 (
`ifndef SRAM_ARB_FIXED_PRIO_EN
   input  logic       ptr,
`endif
   input  logic [1:0] valid,
   output logic [1:0] grant
);
`ifdef SRAM_ARB_FIXED_PRIO_EN
   assign grant[0] = valid[0];
   assign grant[1] = valid[1] & ~valid[0];
`else
   // ptr names the requester that wins a tie
   assign grant[0] = valid[0] & (~valid[1] | ~ptr);
   assign grant[1] = valid[1] & (~valid[0] |  ptr);
`endif
endmodule

// File: rtl/sram_access_arbiter.sv
// Shares a single-port SRAM between I2C (req 0) and host (req 1) with burst locking.
// Build option: SRAM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module sram_access_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W    = SRAM_ADDR_W,
   parameter int DATA_W    = SRAM_DATA_W,
   parameter int MAX_BURST = 8
) (
   input  logic              clock,
   input  logic              reset,
   sram_req_if.slave         bus,
   output logic              mem_en,
   output logic              mem_re_weN,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int               CNT_W    = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   lock_state_e      state, state_nxt;
   logic [CNT_W-1:0] burst_cnt, cnt_nxt;
   logic [1:0]       arb_gnt, ready, acc;
   logic             win, own;
   logic             cmd_id, rsp_rd;
   logic [1:0]       rsp_vld;

`ifdef SRAM_ARB_FIXED_PRIO_EN
   arb_rr2 u_arb (.valid(bus.req_valid), .grant(arb_gnt));
`else
   logic ptr;

   arb_rr2 u_arb (.ptr(ptr), .valid(bus.req_valid), .grant(arb_gnt));

   // Pointer always moves to the loser, which also covers the forced burst release
   always_ff @(posedge clock or posedge reset) begin
      if (reset)     ptr <= REQ_I2C;
      else if (|acc) ptr <= ~win;
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= UNLOCKED;
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         burst_cnt <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = burst_cnt;
      ready     = 2'b00;
      own       = (state == LOCK1) ? REQ_HOST : REQ_I2C;
      case (state)
         UNLOCKED:     ready = arb_gnt;
         LOCK0, LOCK1: ready[own] = bus.req_valid[own];
         default:      ready = 2'b00;
      endcase
      if (reset) ready = 2'b00;
      acc = bus.req_valid & ready;
      win = acc[REQ_HOST] ? REQ_HOST : REQ_I2C;
      case (state)
         // MAX_BURST of 1 means a lock can never outlive its first beat
         UNLOCKED:
            if (|acc && bus.req_lock[win] && MAX_BURST > 1) begin
               state_nxt = (win == REQ_HOST) ? LOCK1 : LOCK0;
               cnt_nxt   = CNT_ONE;
            end
         LOCK0, LOCK1:
            if (!bus.req_valid[own] ||
                (acc[own] && (!bus.req_lock[own] || burst_cnt >= CNT_LAST))) begin
               state_nxt = UNLOCKED;
               cnt_nxt   = '0;
            end else if (acc[own]) begin
               cnt_nxt = burst_cnt + CNT_ONE;
            end
         default: begin
            state_nxt = UNLOCKED;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Command register (N+1) and response register (N+2)
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_en     <= 1'b0;
         mem_re_weN <= 1'b1;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cmd_id     <= REQ_I2C;
         rsp_vld    <= 2'b00;
         rsp_rd     <= 1'b0;
      end else begin
         mem_en <= |acc;
         if (|acc) begin
            mem_re_weN <= ~bus.req_write[win];
            mem_addr   <= win ? bus.req_addr[ADDR_W +: ADDR_W]  : bus.req_addr[0 +: ADDR_W];
            mem_wdata  <= win ? bus.req_wdata[DATA_W +: DATA_W] : bus.req_wdata[0 +: DATA_W];
            cmd_id     <= win;
         end
         rsp_vld <= mem_en ? (cmd_id ? 2'b10 : 2'b01) : 2'b00;
         rsp_rd  <= mem_re_weN;
      end
   end

   assign bus.req_ready = ready;
   assign bus.rsp_valid = rsp_vld;
   assign bus.rsp_rdata = (|rsp_vld && rsp_rd) ? mem_rdata : '0;
endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter with a behavioural 128x8 synchronous SRAM.
module tb_sram_access_arbiter;
   logic       clock = 1'b0;
   logic       reset;
   logic       mem_en, mem_re_weN;
   logic [6:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata = 8'h00;
   logic [7:0] sram [0:127];
   bit         sram_init = 1'b0;
   logic [1:0] first_v;
   int         total = 0;
   int         bad   = 0;

   sram_req_if #(.ADDR_W(7), .DATA_W(8)) bus ();

   sram_access_arbiter #(.ADDR_W(7), .DATA_W(8), .MAX_BURST(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus.slave),
      .mem_en     (mem_en),
      .mem_re_weN (mem_re_weN),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (!sram_init) begin
         for (int i = 0; i < 128; i++) sram[i] <= 8'h00;
         sram[5]   <= 8'hA5;
         sram_init <= 1'b1;
      end else if (mem_en) begin
         if (mem_re_weN) mem_rdata      <= sram[mem_addr];
         else            sram[mem_addr] <= mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic drv(input logic [1:0] v, input logic [1:0] w, input logic [1:0] lk,
                      input logic [6:0] a0, input logic [6:0] a1,
                      input logic [7:0] d0, input logic [7:0] d1);
      bus.req_valid = v;
      bus.req_write = w;
      bus.req_lock  = lk;
      bus.req_addr  = {a1, a0};
      bus.req_wdata = {d1, d0};
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      drv(2'b11, 2'b00, 2'b00, 7'h00, 7'h00, 8'h00, 8'h00);
      tick;
      #1;
      chk("rst_ready", bus.req_ready, 2'b00);
      chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
      chk("rst_rsp_rdata", bus.rsp_rdata, 8'h00);
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_mem_re_weN", mem_re_weN, 1'b1);
      chk("rst_mem_addr", mem_addr, 7'h00);
      chk("rst_mem_wdata", mem_wdata, 8'h00);
      tick;
      reset = 1'b0;
      drv(2'b00, 2'b00, 2'b00, 7'h00, 7'h00, 8'h00, 8'h00);
      tick;

      // both valid, no lock
      drv(2'b11, 2'b00, 2'b00, 7'h01, 7'h02, 8'h00, 8'h00);
      for (int k = 0; k < 4; k++) begin
         #1;
`ifdef SRAM_ARB_FIXED_PRIO_EN
         chk("arb_gnt", bus.req_ready, 2'b01);
`else
         chk("arb_gnt", bus.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
`endif
         tick;
      end
      drv(2'b00, 2'b00, 2'b00, 7'h00, 7'h00, 8'h00, 8'h00);
      tick; tick; tick;

      // single read of addr 0x05 by requester 0
      drv(2'b01, 2'b00, 2'b00, 7'h05, 7'h00, 8'h00, 8'h00);
      #1;
      chk("rd_ready", bus.req_ready, 2'b01);
      tick;
      drv(2'b00, 2'b00, 2'b00, 7'h00, 7'h00, 8'h00, 8'h00);
      chk("rd_mem_en", mem_en, 1'b1);
      chk("rd_mem_re", mem_re_weN, 1'b1);
      chk("rd_mem_addr", mem_addr, 7'h05);
      tick;
      chk("rd_rsp_valid", bus.rsp_valid, 2'b01);
      chk("rd_rsp_rdata", bus.rsp_rdata, 8'hA5);
      tick;

      // requester 1 locks for 3 beats then releases; requester 0 waiting
`ifdef SRAM_ARB_FIXED_PRIO_EN
      first_v = 2'b10;
`else
      first_v = 2'b11;
`endif
      for (int b = 0; b < 4; b++) begin
         drv((b == 0) ? first_v : 2'b11, 2'b00, {(b < 3), 1'b0}, 7'h03, 7'h04, 8'h00, 8'h00);
         #1;
         chk("lock1_gnt", bus.req_ready, 2'b10);
         tick;
      end
      drv(2'b11, 2'b00, 2'b00, 7'h03, 7'h04, 8'h00, 8'h00);
      #1;
      chk("lock1_release", bus.req_ready, 2'b01);
      tick;
      drv(2'b00, 2'b00, 2'b00, 7'h00, 7'h00, 8'h00, 8'h00);
      tick; tick;

      // requester 0 holds lock past MAX_BURST while requester 1 waits
      for (int b = 0; b < 9; b++) begin
         drv((b == 0) ? 2'b01 : 2'b11, 2'b00, 2'b01, 7'h20, 7'h30, 8'h00, 8'h00);
         #1;
`ifdef SRAM_ARB_FIXED_PRIO_EN
         chk("burst_gnt", bus.req_ready, 2'b01);
`else
         chk("burst_gnt", bus.req_ready, (b < 8) ? 2'b01 : 2'b10);
`endif
         tick;
      end
      drv(2'b00, 2'b00, 2'b00, 7'h00, 7'h00, 8'h00, 8'h00);
      tick; tick; tick;

      // write 0x3C to 0x10, read it back on the next beat
      drv(2'b01, 2'b01, 2'b00, 7'h10, 7'h00, 8'h3C, 8'h00);
      #1;
      chk("wr_ready", bus.req_ready, 2'b01);
      tick;
      drv(2'b01, 2'b00, 2'b00, 7'h10, 7'h00, 8'h00, 8'h00);
      chk("wr_mem_en", mem_en, 1'b1);
      chk("wr_mem_we", mem_re_weN, 1'b0);
      chk("wr_mem_addr", mem_addr, 7'h10);
      chk("wr_mem_wdata", mem_wdata, 8'h3C);
      #1;
      chk("raw_ready", bus.req_ready, 2'b01);
      tick;
      drv(2'b00, 2'b00, 2'b00, 7'h00, 7'h00, 8'h00, 8'h00);
      chk("raw_mem_re", mem_re_weN, 1'b1);
      chk("wr_rsp_valid", bus.rsp_valid, 2'b01);
      chk("wr_rsp_rdata", bus.rsp_rdata, 8'h00);
      tick;
      chk("raw_rsp_valid", bus.rsp_valid, 2'b01);
      chk("raw_rsp_rdata", bus.rsp_rdata, 8'h3C);
      tick;

      // reset during the SRAM cycle of a read
      drv(2'b01, 2'b00, 2'b00, 7'h05, 7'h00, 8'h00, 8'h00);
      #1;
      chk("mid_ready", bus.req_ready, 2'b01);
      tick;
      reset = 1'b1;
      drv(2'b11, 2'b00, 2'b00, 7'h05, 7'h06, 8'h00, 8'h00);
      #1;
      chk("mid_rst_mem_en", mem_en, 1'b0);
      chk("mid_rst_mem_re", mem_re_weN, 1'b1);
      chk("mid_rst_mem_addr", mem_addr, 7'h00);
      chk("mid_rst_mem_wdata", mem_wdata, 8'h00);
      chk("mid_rst_ready", bus.req_ready, 2'b00);
      tick;
      chk("mid_rst_rsp_valid", bus.rsp_valid, 2'b00);
      chk("mid_rst_rsp_rdata", bus.rsp_rdata, 8'h00);
      reset = 1'b0;
      #1;
      chk("post_rst_gnt", bus.req_ready, 2'b01);
      tick;
      drv(2'b00, 2'b00, 2'b00, 7'h00, 7'h00, 8'h00, 8'h00);
      chk("post_rst_rsp_valid", bus.rsp_valid, 2'b00);
      tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
